// File: rtl/div_even_detect.sv
// Measures the period and high time of a divided clock in clk_in cycles and locks onto a
// stable even, 50%-duty ratio. The lock decision is registered one cycle after the qualifying rise.
module div_even_detect #(
  parameter int MAX_DIV     = 20,
  parameter int LOCK_COUNT  = 4,
  parameter int SYNC_STAGES = 2,
  localparam int CW         = $clog2(MAX_DIV + 2)
) (
  input  logic          clk_in,
  input  logic          rst_n,
  input  logic          clk_div_in,
  output logic [CW-1:0] ratio_out,
  output logic          locked,
  output logic          err
);

  localparam int MW = $clog2(LOCK_COUNT + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(MAX_DIV + 1);
  localparam logic [CW-1:0] DIV_MAX = CW'(MAX_DIV);
  localparam logic [CW-1:0] DIV_MIN = CW'(2);
  localparam logic [MW-1:0] LOCK_N  = MW'(LOCK_COUNT);

  typedef enum logic [1:0] {IDLE, ACQUIRE, LOCKED} state_t;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s_d_q;
  logic [CW-1:0]          cnt_q, hcnt_q, cand_q, cand_d, ratio_q, ratio_d;
  logic [MW-1:0]          match_q, match_d, match_inc;
  state_t                 state_q, state_d;
  logic                   locked_q, locked_d, err_q, err_d;
  logic                   s, rise, tmo, p_vld;

  assign s         = sync_q[SYNC_STAGES-1];
  assign rise      = s & ~s_d_q;
  assign tmo       = (cnt_q == CNT_MAX) & ~rise;
  assign match_inc = match_q + MW'(1);
  // At a rise, cnt_q holds the just-ended period and hcnt_q its high time.
  assign p_vld = ~cnt_q[0] && (cnt_q >= DIV_MIN) && (cnt_q <= DIV_MAX) &&
                 (hcnt_q == (cnt_q >> 1));

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      s_d_q  <= 1'b0;
      cnt_q  <= '0;
      hcnt_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], clk_div_in};
      s_d_q  <= s;
      if (rise) begin
        cnt_q  <= CW'(1);
        hcnt_q <= CW'(1);
      end else begin
        if (cnt_q != CNT_MAX) cnt_q <= cnt_q + CW'(1);
        if (s && (hcnt_q != CNT_MAX)) hcnt_q <= hcnt_q + CW'(1);
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    match_d  = match_q;
    cand_d   = cand_q;
    ratio_d  = ratio_q;
    locked_d = locked_q;
    err_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (rise) begin
          state_d = ACQUIRE;
          match_d = '0;
        end
      end
      ACQUIRE: begin
        if (rise) begin
          if (p_vld && ((match_q == '0) || (cnt_q == cand_q))) begin
            cand_d  = cnt_q;
            match_d = match_inc;
            if (match_inc == LOCK_N) begin
              state_d  = LOCKED;
              ratio_d  = cnt_q;
              locked_d = 1'b1;
            end
          end else if (p_vld) begin
            cand_d  = cnt_q;
            match_d = MW'(1);
          end else begin
            match_d = '0;
          end
        end else if (tmo) begin
          state_d = IDLE;
          match_d = '0;
        end
      end
      LOCKED: begin
        if ((rise && !(p_vld && (cnt_q == ratio_q))) || tmo) begin
          state_d  = rise ? ACQUIRE : IDLE;
          locked_d = 1'b0;
          err_d    = 1'b1;
          match_d  = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      match_q  <= '0;
      cand_q   <= '0;
      ratio_q  <= '0;
      locked_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      match_q  <= match_d;
      cand_q   <= cand_d;
      ratio_q  <= ratio_d;
      locked_q <= locked_d;
      err_q    <= err_d;
    end
  end

  assign ratio_out = ratio_q;
  assign locked    = locked_q;
  assign err       = err_q;

endmodule

// File: tb/tb_div_even_detect.sv
// Drives directed and random divided-clock waveforms; a period-level model predicts the outputs.
module tb_div_even_detect;

  localparam int MAXD = 20;
  localparam int LCNT = 4;
  localparam int CW   = $clog2(MAXD + 2);
  localparam int M_IDLE = 0, M_ACQ = 1, M_LOCK = 2;

  logic          clk_in = 1'b0;
  logic          rst_n;
  logic          clk_div_in;
  logic [CW-1:0] ratio_out;
  logic          locked;
  logic          err;

  int total = 0, bad = 0, err_cnt = 0, ph = 0;

  // reference model state
  bit hist[$];
  int e, last_e, ms, cand, match, m_ratio;
  logic m_locked, m_err;

  div_even_detect #(.MAX_DIV(MAXD), .LOCK_COUNT(LCNT), .SYNC_STAGES(2)) dut (
    .clk_in(clk_in), .rst_n(rst_n), .clk_div_in(clk_div_in),
    .ratio_out(ratio_out), .locked(locked), .err(err)
  );

  always #5 clk_in = ~clk_in;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic model_reset();
    hist.delete();
    e = 0; last_e = 0; ms = M_IDLE; cand = 0; match = 0;
    m_ratio = 0; m_locked = 1'b0; m_err = 1'b0;
  endtask

  // One clk_in posedge: the sample taken 2 edges ago reaches the rise detector now.
  task automatic model_edge(input logic x);
    int p, h;
    logic cur, prv, rise, tmo, vld;
    hist.push_back(x);
    cur  = (e >= 2) ? hist[e-2] : 1'b0;
    prv  = (e >= 3) ? hist[e-3] : 1'b0;
    rise = cur & ~prv;
    p = (e - last_e > MAXD + 1) ? MAXD + 1 : e - last_e;
    h = 0;
    if (rise)
      for (int j = last_e - 2; j < e - 2; j++)
        if (j >= 0 && hist[j]) h++;
    if (h > MAXD + 1) h = MAXD + 1;
    tmo = !rise && (e - last_e >= MAXD + 1);
    vld = (p % 2 == 0) && (p >= 2) && (p <= MAXD) && (h == p / 2);
    m_err = 1'b0;
    case (ms)
      M_IDLE: if (rise) begin ms = M_ACQ; match = 0; end
      M_ACQ: begin
        if (rise) begin
          if (vld && (match == 0 || p == cand)) begin
            cand = p; match++;
            if (match == LCNT) begin ms = M_LOCK; m_ratio = p; m_locked = 1'b1; end
          end else if (vld) begin
            cand = p; match = 1;
          end else match = 0;
        end else if (tmo) begin
          ms = M_IDLE; match = 0;
        end
      end
      default: begin
        if ((rise && !(vld && p == m_ratio)) || tmo) begin
          ms = rise ? M_ACQ : M_IDLE;
          m_locked = 1'b0; m_err = 1'b1; match = 0;
        end
      end
    endcase
    if (rise) last_e = e;
    e++;
  endtask

  task automatic step(input int period, input int high);
    @(negedge clk_in);
    if (rst_n) model_edge(clk_div_in); else model_reset();
    chk("locked", {31'd0, locked}, {31'd0, m_locked});
    chk("ratio_out", {{(32-CW){1'b0}}, ratio_out}, m_ratio);
    chk("err", {31'd0, err}, {31'd0, m_err});
    if (err === 1'b1) err_cnt++;
    clk_div_in = (ph < high);
    ph = (ph + 1) % period;
  endtask

  task automatic run(input int period, input int high, input int n);
    ph = 0;
    repeat (n) step(period, high);
  endtask

  initial begin
    int p, hi, n;
    rst_n = 1'b0;
    clk_div_in = 1'b0;
    model_reset();
    run(1, 0, 3);
    chk("rst_ratio", {{(32-CW){1'b0}}, ratio_out}, 0);
    chk("rst_locked", {31'd0, locked}, 0);
    chk("rst_err", {31'd0, err}, 0);
    rst_n = 1'b1;

    run(6, 3, 60);
    chk("div6_locked", {31'd0, locked}, 1);
    chk("div6_ratio", {{(32-CW){1'b0}}, ratio_out}, 6);
    chk("div6_no_err", err_cnt, 0);

    run(8, 4, 60);
    chk("div8_locked", {31'd0, locked}, 1);
    chk("div8_ratio", {{(32-CW){1'b0}}, ratio_out}, 8);
    chk("div8_one_err", err_cnt, 1);

    run(1, 0, 40);
    chk("hold0_locked", {31'd0, locked}, 0);
    chk("hold0_ratio_kept", {{(32-CW){1'b0}}, ratio_out}, 8);
    chk("hold0_err", err_cnt, 2);

    run(8, 2, 100);
    chk("duty25_unlocked", {31'd0, locked}, 0);
    run(22, 11, 150);
    chk("p22_unlocked", {31'd0, locked}, 0);
    chk("no_err_unlocked", err_cnt, 2);

    run(2, 1, 30);
    chk("div2_locked", {31'd0, locked}, 1);
    chk("div2_ratio", {{(32-CW){1'b0}}, ratio_out}, 2);

    rst_n = 1'b0;
    #1;
    chk("midrst_ratio", {{(32-CW){1'b0}}, ratio_out}, 0);
    chk("midrst_locked", {31'd0, locked}, 0);
    run(2, 1, 3);
    rst_n = 1'b1;
    run(2, 1, 30);
    chk("relock_locked", {31'd0, locked}, 1);
    chk("relock_ratio", {{(32-CW){1'b0}}, ratio_out}, 2);

    repeat (25) begin
      p  = $urandom_range(2, 24);
      hi = ($urandom_range(0, 1) == 1) ? p / 2 : $urandom_range(0, p);
      n  = $urandom_range(20, 150);
      run(p, hi, n);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
